// File: rtl/uart_tx_if.sv
// Upstream word handshake for the UART transmitter.
// valid/ready: a word transfers on the rising clk edge where tx_valid && tx_ready; tx_data is only meaningful in that cycle.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits, paced by s_tick.
// Parity stage is built only when the macro UART_TX_PARITY_EN is defined.
module uart_tx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   uart_tx_if.slave   up,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done_tick,
   output logic [2:0] state_dbg
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE > 32 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_tx_param: parameter out of legal range");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 advance;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      stop_d   = stop_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      done_d   = 1'b0;
      advance  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      // An s_tick in the accept cycle is deliberately not counted.
      if (state_q == S_IDLE) begin
         tx_d = 1'b1;
         if (up.tx_valid) begin
            shift_d  = up.tx_data;
`ifdef UART_TX_PARITY_EN
            parity_d = (^up.tx_data) ^ 1'(PARITY_ODD);
`endif
            state_d  = S_START;
            tx_d     = 1'b0;
            tick_d   = '0;
         end
      end else if (s_tick) begin
         if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            advance = 1'b1;
         end else begin
            tick_d = tick_q + TW'(1);
         end
      end

      if (advance) begin
         unique case (state_q)
            S_START: begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               bit_d   = '0;
            end
            S_DATA: begin
               if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
                  stop_d  = 1'b0;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + BW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               state_d = S_STOP;
               tx_d    = 1'b1;
               stop_d  = 1'b0;
            end
`endif
            S_STOP: begin
               if (stop_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign up.tx_ready   = (state_q == S_IDLE);
   assign tx_busy       = (state_q != S_IDLE);
   assign tx            = tx_q;
   assign tx_done_tick  = done_q;
   assign state_dbg     = state_q;
endmodule
